sng_arbiter: RTL
================

Name: sng_arbiter

Overview:
- Round-robin scheduler that shares one stochastic number generator (SNG) instance among N_REQ requesters.
- Grants one requester at a time and latches its binary operand.
- Restarts the SNG with a one-cycle active-low reset pulse, waits for its done flag, captures the bitstream and returns it through a valid/ready output port tagged with the requester id.
- Sits between the FPU operand front-end and the shared SNG.

Parameters:
- N_REQ, 4, number of requesters (>=2)
- BSL, 255, bitstream length; must equal the attached SNG's bsl
- REG_WIDTH, $clog2(BSL), operand width; must equal the attached SNG's reg_width
- TMO, 1023, WAIT-state watchdog limit in cycles (> BSL+2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- req  in  N_REQ  per-requester conversion request; level, held until gnt
- req_val  in  N_REQ*REG_WIDTH  packed operands; requester i occupies bits [i*REG_WIDTH +: REG_WIDTH]
- gnt  out  N_REQ  one-hot, one-cycle grant pulse
- sng_rst_n  out  1  drives SNG rst; low = restart
- sng_a  out  REG_WIDTH  drives SNG a; latched operand
- sng_done  in  1  SNG done
- sng_bs  in  BSL  SNG a_sbs
- out_bs  out  BSL  captured bitstream
- out_id  out  $clog2(N_REQ)  index of requester owning out_bs
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- busy  out  1  high in every state except IDLE
- err  out  1  sticky watchdog error

Behaviour:
- Reset (rst=0 at a clock edge):
  - state=IDLE; gnt=0, out_valid=0, out_bs=0, out_id=0, sng_a=0, err=0, busy=0.
  - rr_ptr=N_REQ-1, so requester 0 has first priority.
  - sng_rst_n=0 throughout reset, which also resets the SNG.
  - Reset mid-operation aborts the conversion and discards any pending result.
- States: IDLE, START, WAIT, OUT. All outputs are registered.
- IDLE:
  - sng_rst_n=1.
  - If any req bit is set, select the first set bit searching from rr_ptr+1 upward, wrapping modulo N_REQ.
  - On that edge: gnt[k]=1 for one cycle, sng_a<=req_val[k], out_id<=k, rr_ptr<=k, go to START.
  - If no req, stay in IDLE.
- START:
  - Exactly one cycle with sng_rst_n=0; sng_a held.
  - sng_done is ignored here (it may still be high from the previous conversion).
  - Clear the watchdog counter; go to WAIT.
- WAIT:
  - sng_rst_n=1; the watchdog counter increments each cycle.
  - On sng_done=1: out_bs<=sng_bs, out_valid<=1, go to OUT.
  - If the counter reaches TMO first: err<=1 (sticky), no output, go to IDLE.
  - Done takes priority over timeout when both occur in the same cycle.
- OUT:
  - out_valid=1; out_bs and out_id stay stable until out_ready=1.
  - On the handshake edge: out_valid<=0, go to IDLE.
  - A new grant can occur no earlier than the cycle after the return to IDLE; requests arriving meanwhile wait.
- sng_a changes only on a grant edge; it is stable for the whole conversion.
- Fairness: a requester holding req is granted within N_REQ conversions.
  - The requester just granted is lowest priority at the next arbitration.
- gnt is never asserted outside IDLE. A req drop before gnt is allowed; that requester is simply skipped.
- Latency from a req edge in IDLE to out_valid:
  - 1 (grant) + 1 (START) + SNG run time + 1 (capture) cycles.
  - For the 8-bit LFSR SNG with BSL=255, out_valid rises 259 cycles after the grant edge.

Test Plan:
- Single request: req=4'b0001, req_val[0]=128 -> gnt=0001 one cycle; one sng_rst_n low cycle; out_valid after sng_done; out_id=0; popcount(out_bs) within ±8 of 128; busy low after the handshake.
- Round robin: req=4'b1111 held, out_ready=1 -> grant order 0,1,2,3,0; out_id sequence matches; no gnt while busy=1.
- Backpressure: out_ready=0 for 20 cycles after out_valid -> out_bs and out_id stable and no new gnt; release -> IDLE, next gnt one cycle later.
- Stale done: after a completed conversion (sng_done still 1), request requester 2 -> no capture in START; capture only after the new conversion's done; the bitstream matches operand 2.
- Watchdog: SNG model holds done=0, TMO=300 -> err=1 from 300 cycles after entering WAIT; out_valid never set; the next request is still served; err stays 1 until rst=0.
- Reset mid-WAIT: rst=0 for one edge at cycle 100 of a conversion -> all outputs at reset values, sng_rst_n=0, rr_ptr=N_REQ-1, so requester 0 is granted first afterwards.

Source files
------------

// File: rtl/sng_arbiter_if.sv
// sng_arbiter_if
//   Bundles the request side, the shared-SNG side and the result side of the
//   SNG round-robin arbiter.
//   Signals:
//     req, req_val          : per-requester level request and packed operands
//     gnt                   : one-hot grant pulse
//     sng_rst_n, sng_a      : SNG restart (low = restart) and operand
//     sng_done, sng_bs      : SNG done flag and bitstream
//     out_bs, out_id        : captured bitstream and owning requester
//     out_valid, out_ready  : result handshake
//     busy, err             : not-idle flag and sticky watchdog error
//   Modports:
//     master : arbiter view
//     slave  : environment view (requesters, SNG, result consumer)
interface sng_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int BSL       = 255,
  parameter int REG_WIDTH = $clog2(BSL),
  parameter int ID_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]           req;
  logic [N_REQ*REG_WIDTH-1:0] req_val;
  logic [N_REQ-1:0]           gnt;
  logic                       sng_rst_n;
  logic [REG_WIDTH-1:0]       sng_a;
  logic                       sng_done;
  logic [BSL-1:0]             sng_bs;
  logic [BSL-1:0]             out_bs;
  logic [ID_W-1:0]            out_id;
  logic                       out_valid;
  logic                       out_ready;
  logic                       busy;
  logic                       err;

  modport master (
    input  req, req_val, sng_done, sng_bs, out_ready,
    output gnt, sng_rst_n, sng_a, out_bs, out_id, out_valid, busy, err
  );

  modport slave (
    output req, req_val, sng_done, sng_bs, out_ready,
    input  gnt, sng_rst_n, sng_a, out_bs, out_id, out_valid, busy, err
  );
endinterface

// File: rtl/sng_arbiter.sv
// sng_arbiter
//   Round-robin scheduler sharing one stochastic number generator among
//   N_REQ requesters. A granted requester's operand is latched onto sng_a,
//   the SNG is restarted with a one-cycle low pulse on sng_rst_n, and the
//   bitstream is captured on sng_done and returned through a valid/ready
//   port tagged with the requester id. A watchdog aborts a conversion whose
//   done never arrives and raises a sticky err.
//   Ports:
//     clk : clock
//     rst : synchronous reset, active-low (also holds the SNG in reset)
//     bus : sng_arbiter_if.master (request, SNG and result signals)
module sng_arbiter #(
  parameter int N_REQ     = 4,
  parameter int BSL       = 255,
  parameter int REG_WIDTH = $clog2(BSL),
  parameter int TMO       = 1023
) (
  input  logic          clk,
  input  logic          rst,
  sng_arbiter_if.master bus
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TMO + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t               state_r, state_s;
  logic [N_REQ-1:0]     gnt_r, gnt_s;
  logic                 sng_rst_n_r, sng_rst_n_s;
  logic [REG_WIDTH-1:0] sng_a_r, sng_a_s;
  logic [BSL-1:0]       out_bs_r, out_bs_s;
  logic [ID_W-1:0]      out_id_r, out_id_s;
  logic                 out_valid_r, out_valid_s;
  logic                 busy_r, busy_s;
  logic                 err_r, err_s;
  logic [ID_W-1:0]      rr_ptr_r, rr_ptr_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [ID_W:0]        pick_s;
  logic [REG_WIDTH-1:0] opnd_s [N_REQ];

  // First set request after p, wrapping; MSB flags a hit. Scanning from the
  // far end lets the nearest candidate overwrite earlier ones.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [ID_W-1:0]  p);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = ID_W'((int'(p) + i) % N_REQ);
      res = r[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  for (genvar g = 0; g < N_REQ; g++) begin : g_opnd
    assign opnd_s[g] = bus.req_val[g*REG_WIDTH +: REG_WIDTH];
  end

  // Next-state and next-register decode.
  always_comb begin
    pick_s      = rr_pick(bus.req, rr_ptr_r);
    state_s     = state_r;
    gnt_s       = '0;
    sng_rst_n_s = 1'b1;
    sng_a_s     = sng_a_r;
    out_bs_s    = out_bs_r;
    out_id_s    = out_id_r;
    out_valid_s = out_valid_r;
    err_s       = err_r;
    rr_ptr_s    = rr_ptr_r;
    cnt_s       = cnt_r;
    case (state_r)
      IDLE: begin
        if (pick_s[ID_W]) begin
          state_s     = START;
          gnt_s       = {{(N_REQ-1){1'b0}}, 1'b1} << pick_s[ID_W-1:0];
          sng_rst_n_s = 1'b0;  // low exactly during START
          sng_a_s     = opnd_s[pick_s[ID_W-1:0]];
          out_id_s    = pick_s[ID_W-1:0];
          rr_ptr_s    = pick_s[ID_W-1:0];
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        // sng_done may still be high from the previous run; not looked at here.
        state_s = WAIT;
        cnt_s   = '0;
      end
      WAIT: begin
        if (bus.sng_done) begin
          state_s     = OUT;
          out_bs_s    = bus.sng_bs;
          out_valid_s = 1'b1;
        end else if (cnt_r == CNT_W'(TMO - 1)) begin
          state_s = IDLE;
          err_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_s     = IDLE;
          out_valid_s = 1'b0;
        end else begin
          state_s = OUT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Registered outputs, round-robin pointer and watchdog counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_r       <= '0;
      sng_rst_n_r <= 1'b0;
      sng_a_r     <= '0;
      out_bs_r    <= '0;
      out_id_r    <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      rr_ptr_r    <= ID_W'(N_REQ - 1);
      cnt_r       <= '0;
    end else begin
      gnt_r       <= gnt_s;
      sng_rst_n_r <= sng_rst_n_s;
      sng_a_r     <= sng_a_s;
      out_bs_r    <= out_bs_s;
      out_id_r    <= out_id_s;
      out_valid_r <= out_valid_s;
      busy_r      <= busy_s;
      err_r       <= err_s;
      rr_ptr_r    <= rr_ptr_s;
      cnt_r       <= cnt_s;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.sng_rst_n = sng_rst_n_r;
  assign bus.sng_a     = sng_a_r;
  assign bus.out_bs    = out_bs_r;
  assign bus.out_id    = out_id_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.err       = err_r;

endmodule
